// File: rtl/mem_pkg.sv
// Shared constants and types for the dual-port RAM controller.
// Init pattern, read-during-write selectors and init FSM state.
package mem_pkg;

  localparam int INIT_ZERO       = 0;
  localparam int INIT_INDEX      = 1;
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } init_state_e;

endpackage

// File: rtl/mem_init_seq.sv
// Preload sequencer: sweeps every address once after reset,
// then flags the memory as ready for port traffic.
module mem_init_seq
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int INIT_MODE = INIT_INDEX
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  init_state_e       state;
  init_state_e       state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    unique case (state)
      ST_INIT: begin
        // No storage writes while reset is held.
        init_we = rst_n;
        if (cnt == LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign init_addr = cnt;
  assign init_data = (INIT_MODE == INIT_INDEX)
                   ? DATA_W'(cnt)
                   : '0;
  assign init_done = (state == ST_RUN);

endmodule

// File: rtl/dp_ram_ctrl.sv
// True dual-port RAM with byte enables, registered reads,
// port-A-wins write arbitration and a reset-driven preload.
module dp_ram_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int INIT_MODE = INIT_INDEX,
  parameter int RDW_MODE  = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                init_done,
  output logic                collision
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  logic              run;
  logic              a_go;
  logic              a_wr;
  logic              b_go;
  logic              b_wr;
  logic [DATA_W-1:0] a_old;
  logic [DATA_W-1:0] b_old;
  logic [DATA_W-1:0] a_merged;
  logic [DATA_W-1:0] b_merged;
  logic [DATA_W-1:0] a_ret;
  logic [DATA_W-1:0] b_ret;
  logic              same_addr;

  mem_init_seq #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_MODE(INIT_MODE)
  ) u_init (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .init_done(init_done)
  );

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    end
    return r;
  endfunction

  // Requests arriving before preload completes are dropped.
  assign run  = init_done & rst_n;
  assign a_go = run & a_en;
  assign b_go = run & b_en;
  assign a_wr = a_go & a_we;
  assign b_wr = b_go & b_we;

  assign same_addr = (a_addr == b_addr);

  always_comb begin
    a_old    = mem[a_addr];
    b_old    = mem[b_addr];
    a_merged = merge(a_old, a_wdata, a_be);
    b_merged = merge(b_old, b_wdata, b_be);
    a_ret    = a_old;
    b_ret    = b_old;
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      if (a_we) a_ret = a_merged;
      if (b_we) b_ret = b_merged;
    end
  end

  // Port A bytes are applied last so they win on shared bytes.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (b_wr && b_be[k])
          mem[b_addr][k*8 +: 8] <= b_wdata[k*8 +: 8];
      end
      for (int k = 0; k < NB; k++) begin
        if (a_wr && a_be[k])
          mem[a_addr][k*8 +: 8] <= a_wdata[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rdata   <= '0;
      a_rvalid  <= 1'b0;
      b_rdata   <= '0;
      b_rvalid  <= 1'b0;
      collision <= 1'b0;
    end else begin
      a_rvalid  <= a_go;
      b_rvalid  <= b_go;
      collision <= a_wr & b_wr & same_addr;
      if (a_go) a_rdata <= a_ret;
      if (b_go) b_rdata <= b_ret;
    end
  end

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Scoreboard bench: two controllers (read-first, write-first)
// share one stimulus stream; a monitor checks every response.
module tb_dp_ram_ctrl;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_we, b_en, b_we;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic        a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
  logic        done0, done1, coll0, coll1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t  q [4][$];
  int    qc[2][$];
  string pn[4] = '{"d0_a", "d0_b", "d1_a", "d1_b"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dp_ram_ctrl #(
    .DATA_W(32), .DEPTH(16), .INIT_MODE(1), .RDW_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
    .init_done(done0), .collision(coll0)
  );

  dp_ram_ctrl #(
    .DATA_W(32), .DEPTH(16), .INIT_MODE(1), .RDW_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
    .init_done(done1), .collision(coll1)
  );

  task automatic chk_eq(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic chk_port(input int p, input logic rv,
                          input logic [31:0] rd);
    exp_t e;
    if (rv) begin
      checks++;
      if (q[p].size() == 0) begin
        failures++;
        $display("FAIL %s unexpected rvalid rdata=%h", pn[p], rd);
      end else begin
        e = q[p].pop_front();
        if (rd !== e.d || cyc - e.c != 1) begin
          failures++;
          $display("FAIL %s rdata=%h lat=%0d expected=%h lat=1",
                   pn[p], rd, cyc - e.c, e.d);
        end
      end
    end
  endtask

  task automatic chk_coll(input int p, input logic c);
    int t;
    if (c) begin
      checks++;
      if (qc[p].size() == 0) begin
        failures++;
        $display("FAIL coll%0d unexpected pulse got=1 expected=0", p);
      end else begin
        t = qc[p].pop_front();
        if (cyc - t != 1) begin
          failures++;
          $display("FAIL coll%0d lat=%0d expected=1", p, cyc - t);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    chk_port(0, a_rvalid0, a_rdata0);
    chk_port(1, b_rvalid0, b_rdata0);
    chk_port(2, a_rvalid1, a_rdata1);
    chk_port(3, b_rvalid1, b_rdata1);
    chk_coll(0, coll0);
    chk_coll(1, coll1);
  end

  task automatic issue(
    input logic ae, aw, input logic [3:0] abe, aad,
    input logic [31:0] awd, ax0, ax1,
    input logic ben, bw, input logic [3:0] bbe, bad,
    input logic [31:0] bwd, bx0, bx1
  );
    @(negedge clk);
    a_en = ae;  a_we = aw;  a_be = abe;  a_addr = aad;  a_wdata = awd;
    b_en = ben; b_we = bw;  b_be = bbe;  b_addr = bad;  b_wdata = bwd;
    if (ae) begin
      q[0].push_back('{ax0, cyc});
      q[2].push_back('{ax1, cyc});
    end
    if (ben) begin
      q[1].push_back('{bx0, cyc});
      q[3].push_back('{bx1, cyc});
    end
    if (ae && aw && ben && bw && aad == bad) begin
      qc[0].push_back(cyc);
      qc[1].push_back(cyc);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    a_en = 1'b0; a_we = 1'b0;
    b_en = 1'b0; b_we = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done0 && n < 40);
    chk_eq({nm, "_cycles"}, n, 16);
    chk_eq({nm, "_done1"}, {31'b0, done1}, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
    b_en = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_rdata", a_rdata0 | b_rdata0 | a_rdata1 | b_rdata1, 0);
    chk_eq("rst_rvalid",
           {28'b0, a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1}, 0);
    chk_eq("rst_done", {30'b0, done0, done1}, 0);
    chk_eq("rst_coll", {30'b0, coll0, coll1}, 0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init1");

    // ae aw be ad wdata x0 x1 | be bw be ad wdata x0 x1
    issue(1,0,4'h0,4'd10,0,32'hA,32'hA, 0,0,0,0,0,0,0);
    issue(1,1,4'h5,4'd3,32'hDEADBEEF,32'h3,32'h00AD00EF,
          0,0,0,0,0,0,0);
    issue(1,0,4'h0,4'd3,0,32'h00AD00EF,32'h00AD00EF,
          0,0,0,0,0,0,0);
    issue(1,1,4'hF,4'd5,32'h11111111,32'h5,32'h11111111,
          1,1,4'hF,4'd5,32'h22222222,32'h5,32'h22222222);
    issue(1,0,4'h0,4'd5,0,32'h11111111,32'h11111111,
          0,0,0,0,0,0,0);
    issue(1,1,4'h3,4'd6,32'hAAAAAAAA,32'h6,32'h0000AAAA,
          1,1,4'h6,4'd6,32'hBBBBBBBB,32'h6,32'h00BBBB06);
    issue(1,0,4'h0,4'd6,0,32'h00BBAAAA,32'h00BBAAAA,
          1,0,4'h0,4'd5,0,32'h11111111,32'h11111111);
    issue(1,1,4'hF,4'd7,32'hCAFE0000,32'h7,32'hCAFE0000,
          1,0,4'h0,4'd7,0,32'h7,32'h7);
    issue(1,1,4'h0,4'd9,32'h12345678,32'h9,32'h9,
          1,0,4'h0,4'd7,0,32'hCAFE0000,32'hCAFE0000);
    issue(1,0,4'h0,4'd9,0,32'h9,32'h9,
          1,1,4'hF,4'd14,32'h77,32'hE,32'h77);
    issue(1,0,4'h0,4'd14,0,32'h77,32'h77,
          1,0,4'h0,4'd15,0,32'hF,32'hF);
    idle();
    repeat (3) @(negedge clk);

    // Restart, then reset again part-way through the sweep.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk_eq("mid_done", {31'b0, done0}, 0);
    @(negedge clk);
    rst_n = 1'b0;
    a_en = 1; a_we = 1; a_be = 4'hF; a_addr = 4'd2;
    a_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init2");
    a_en = 0; a_we = 0;
    chk_eq("init_rvalid", {30'b0, a_rvalid0, a_rvalid1}, 0);

    issue(1,0,4'h0,4'd2,0,32'h2,32'h2, 0,0,0,0,0,0,0);
    issue(1,0,4'h0,4'd3,0,32'h3,32'h3,
          1,0,4'h0,4'd5,0,32'h5,32'h5);
    issue(1,0,4'h0,4'd14,0,32'hE,32'hE, 0,0,0,0,0,0,0);
    idle();
    repeat (4) @(negedge clk);

    for (int p = 0; p < 4; p++)
      chk_eq({pn[p], "_pending"}, q[p].size(), 0);
    chk_eq("coll0_pending", qc[0].size(), 0);
    chk_eq("coll1_pending", qc[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
